// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: sequencer state encoding and the architectural reset PC.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  // WAIT and DRAIN both have a granted request whose response is still owed.
  function automatic logic is_waiting(fetch_state_t s);
    return (s == WAIT) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: one imem request at a time, owns pc_f, holds the word for IF/ID.
// Latency: valid_f 2 cycles after imem_req; stall holds the word, flush drops it and any stale response.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] next_pc,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_f,
  output logic [31:0] instr_f,
  output logic        valid_f,
  output logic        imem_timeout
);

  localparam logic [7:0] TO_MAX = 8'(TIMEOUT);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [7:0]   wait_cnt_q, wait_cnt_d;
  logic         timeout_q, timeout_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= REQ;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      wait_cnt_q <= 8'h0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;

    case (state_q)
      REQ: begin
        if (flush) begin
          pc_d = flush_pc;
          // An accepted request still owes a response that must be swallowed.
          if (imem_gnt) state_d = DRAIN;
        end else if (imem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (flush) begin
          pc_d    = flush_pc;
          state_d = imem_rvalid ? REQ : DRAIN;
        end else if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (flush) begin
          pc_d    = flush_pc;
          state_d = REQ;
        end else if (!stall) begin
          pc_d    = next_pc;
          state_d = REQ;
        end
      end
      DRAIN: begin
        if (flush) pc_d = flush_pc;
        if (imem_rvalid) state_d = REQ;
      end
      default: state_d = REQ;
    endcase
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (is_waiting(state_d) && (state_d != state_q)) begin
      wait_cnt_d = 8'h0;
    end else if (is_waiting(state_q)) begin
      wait_cnt_d = (wait_cnt_q >= TO_MAX) ? TO_MAX : wait_cnt_q + 8'd1;
    end
    timeout_d = timeout_q | (wait_cnt_d == TO_MAX);
  end

  assign imem_req     = (state_q == REQ);
  assign imem_addr    = pc_q;
  assign pc_f         = pc_q;
  assign instr_f      = instr_q;
  assign valid_f      = (state_q == HOLD);
  assign imem_timeout = timeout_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a transaction-level reference model checked every cycle.
module tb_fetch_ctrl;

  localparam logic [7:0] TB_TO = 8'd4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] next_pc;
  logic        stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc_f;
  logic [31:0] instr_f;
  logic        valid_f;
  logic        imem_timeout;

  int n_chk  = 0;
  int n_pass = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  fetch_ctrl #(
    .RESET_PC(32'h0000_3000),
    .TIMEOUT (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .next_pc     (next_pc),
    .stall       (stall),
    .flush       (flush),
    .flush_pc    (flush_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .pc_f        (pc_f),
    .instr_f     (instr_f),
    .valid_f     (valid_f),
    .imem_timeout(imem_timeout)
  );

  // Model tracks transactions: a held word, an owed response, and whether that response is stale.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        have_word;
    logic        owed;
    logic        stale;
    logic [7:0]  cnt;
    logic        to;
  } model_t;

  model_t m;

  function automatic model_t m_next(model_t s);
    model_t n;
    logic   can_req, issue, resp, go_stale;
    n = s;
    if (!reset) begin
      n = '{pc: 32'h0000_3000, instr: 32'h0, have_word: 1'b0, owed: 1'b0,
            stale: 1'b0, cnt: 8'h0, to: 1'b0};
      return n;
    end
    can_req  = !s.have_word && !s.owed;
    issue    = can_req && imem_gnt;
    resp     = s.owed && imem_rvalid;
    go_stale = flush && s.owed && !s.stale && !imem_rvalid;
    if (s.owed && !go_stale) n.cnt = (s.cnt >= TB_TO) ? TB_TO : s.cnt + 8'd1;
    if (resp) begin
      n.owed  = 1'b0;
      n.stale = 1'b0;
      if (!s.stale && !flush) begin
        n.instr     = imem_rdata;
        n.have_word = 1'b1;
      end
    end
    if (issue) begin
      n.owed  = 1'b1;
      n.stale = flush;
      n.cnt   = 8'h0;
    end
    if (go_stale) begin
      n.stale = 1'b1;
      n.cnt   = 8'h0;
    end
    if (flush) begin
      n.pc        = flush_pc;
      n.have_word = 1'b0;
    end else if (s.have_word && !stall) begin
      n.pc        = next_pc;
      n.have_word = 1'b0;
    end
    n.to = s.to || (n.cnt == TB_TO);
    return n;
  endfunction

  always @(posedge clk) m <= m_next(m);

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk1 ("model_req",     imem_req,     !m.have_word && !m.owed);
      chk32("model_addr",    imem_addr,    m.pc);
      chk32("model_pc",      pc_f,         m.pc);
      chk1 ("model_valid",   valid_f,      m.have_word);
      chk32("model_instr",   instr_f,      m.instr);
      chk1 ("model_timeout", imem_timeout, m.to);
    end
  end

  task automatic cyc(input logic g, input logic rv, input logic [31:0] rd,
                     input logic st, input logic fl, input logic [31:0] fpc);
    imem_gnt    = g;
    imem_rvalid = rv;
    imem_rdata  = rd;
    stall       = st;
    flush       = fl;
    flush_pc    = fpc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; next_pc = 32'h0; stall = 1'b0; flush = 1'b0; flush_pc = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b1;
    chk_en = 1'b1;
    chk1 ("rst_req",     imem_req,     1'b1);
    chk32("rst_addr",    imem_addr,    32'h0000_3000);
    chk1 ("rst_valid",   valid_f,      1'b0);
    chk32("rst_instr",   instr_f,      32'h0);
    chk1 ("rst_timeout", imem_timeout, 1'b0);

    // Minimum-latency fetch
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk1("t1_req_dropped", imem_req, 1'b0);
    cyc(1'b0, 1'b1, 32'h3402_0001, 1'b0, 1'b0, 32'h0);
    chk1 ("t1_valid", valid_f, 1'b1);
    chk32("t1_instr", instr_f, 32'h3402_0001);
    chk32("t1_pc",    pc_f,    32'h0000_3000);

    // Stall holds the word, then consume
    next_pc = 32'h0000_3004;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      chk1 ("t2_stall_valid", valid_f, 1'b1);
      chk32("t2_stall_pc",    pc_f,    32'h0000_3000);
    end
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk1 ("t2_req",   imem_req,  1'b1);
    chk32("t2_addr",  imem_addr, 32'h0000_3004);
    chk1 ("t2_valid", valid_f,   1'b0);

    // Branch at 0x3004, delay slot at 0x3008, target 0x3020
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'h1000_0005, 1'b0, 1'b0, 32'h0);
    next_pc = 32'h0000_3008;
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk32("t3_slot_addr", imem_addr, 32'h0000_3008);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'h2108_0001, 1'b0, 1'b0, 32'h0);
    chk32("t3_slot_pc", pc_f, 32'h0000_3008);
    next_pc = 32'h0000_3020;
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk1 ("t3_req",    imem_req,  1'b1);
    chk32("t3_target", imem_addr, 32'h0000_3020);

    // Flush in WAIT, second flush in DRAIN, stale response dropped
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_4100);
    chk1 ("t4_drain_req", imem_req, 1'b0);
    chk32("t4_drain_pc",  pc_f,     32'h0000_4100);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_4180);
    chk1 ("t4_drain2_req", imem_req, 1'b0);
    chk32("t4_drain2_pc",  pc_f,     32'h0000_4180);
    cyc(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    chk1 ("t4_req",   imem_req,  1'b1);
    chk32("t4_addr",  imem_addr, 32'h0000_4180);
    chk1 ("t4_valid", valid_f,   1'b0);
    chk32("t4_instr", instr_f,   32'h2108_0001);

    // Flush coincident with grant
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_4200);
    chk1 ("t5a_req", imem_req, 1'b0);
    chk32("t5a_pc",  pc_f,     32'h0000_4200);
    cyc(1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0);
    chk1 ("t5a_req2",  imem_req,  1'b1);
    chk32("t5a_addr",  imem_addr, 32'h0000_4200);
    chk32("t5a_instr", instr_f,   32'h2108_0001);

    // Flush coincident with response
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'h1111_1111, 1'b0, 1'b1, 32'h0000_4300);
    chk1 ("t5b_req",   imem_req,  1'b1);
    chk32("t5b_addr",  imem_addr, 32'h0000_4300);
    chk1 ("t5b_valid", valid_f,   1'b0);
    chk32("t5b_instr", instr_f,   32'h2108_0001);

    // Flush in REQ before grant retargets the request
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_4380);
    chk1 ("t5c_req",  imem_req,  1'b1);
    chk32("t5c_addr", imem_addr, 32'h0000_4380);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'h8C08_0000, 1'b0, 1'b0, 32'h0);
    chk1 ("t5c_valid", valid_f, 1'b1);
    chk32("t5c_instr", instr_f, 32'h8C08_0000);
    chk32("t5c_pc",    pc_f,    32'h0000_4380);

    // Flush beats stall in HOLD
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_4400);
    chk1 ("t5d_valid", valid_f,   1'b0);
    chk1 ("t5d_req",   imem_req,  1'b1);
    chk32("t5d_addr",  imem_addr, 32'h0000_4400);
    chk32("t5d_instr", instr_f,   32'h8C08_0000);

    // Timeout with TIMEOUT=4, sticky until reset
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    repeat (3) cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk1("t6_before", imem_timeout, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk1("t6_rise", imem_timeout, 1'b1);
    cyc(1'b0, 1'b1, 32'hBBBB_0000, 1'b1, 1'b0, 32'h0);
    chk1 ("t6_sticky", imem_timeout, 1'b1);
    chk1 ("t6_valid",  valid_f,      1'b1);
    chk32("t6_instr",  instr_f,      32'hBBBB_0000);
    reset = 1'b0;
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    reset = 1'b1;
    chk1 ("t6_rst_timeout", imem_timeout, 1'b0);
    chk32("t6_rst_addr",    imem_addr,    32'h0000_3000);
    chk1 ("t6_rst_req",     imem_req,     1'b1);
    chk1 ("t6_rst_valid",   valid_f,      1'b0);
    chk32("t6_rst_instr",   instr_f,      32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences the fetch stage around the next-PC unit in the 5-stage MIPS pipeline: owns pcF, issues one instruction-memory request at a time over a req/gnt/rvalid handshake, and holds the fetched word for IF/ID.
- Advances pcF to the next-PC unit's output, so branch/jump/jr targets from D land after the delay slot.
- Honours hazard-unit stalls and exception/eret redirects (flush), and drops any in-flight response that a flush makes stale.

Parameters:
- RESET_PC, 32'h0000_3000, pcF value after reset.
- TIMEOUT, 64, WAIT/DRAIN cycles before imem_timeout asserts; range 2..255.

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  synchronous, active-low; 0 at a posedge resets the block.
- next_pc  in  32  from the next-PC unit; computed combinationally from pc_f and D-stage control.
- stall  in  1  hazard unit; 1 = IF/ID must not accept.
- flush  in  1  redirect pulse; highest priority.
- flush_pc  in  32  redirect target, sampled when flush=1.
- imem_req  out  1  request valid.
- imem_addr  out  32  request address, always equal to pc_f.
- imem_gnt  in  1  request accepted this cycle; only meaningful while imem_req=1.
- imem_rvalid  in  1  response valid; at most one per granted request, at least 1 cycle after gnt.
- imem_rdata  in  32  response word.
- pc_f  out  32  current fetch PC to IF/ID and the next-PC unit.
- instr_f  out  32  fetched instruction.
- valid_f  out  1  instr_f/pc_f pair is valid for IF/ID.
- imem_timeout  out  1  sticky error flag.

Behaviour:
- Reset (reset=0 at posedge): pc_f=RESET_PC, state=REQ, instr_f=0, valid_f=0, wait_cnt=0, imem_timeout=0. A reset mid-operation abandons any outstanding request; the memory side is reset in the same cycle.
- imem_req is 1 exactly in state REQ. valid_f is 1 exactly in state HOLD.
- States and transitions, with flush evaluated first:
- REQ, no flush: on gnt go to WAIT; otherwise stay.
- REQ, flush with gnt=0: pc_f<=flush_pc; stay in REQ. The address may change before grant.
- REQ, flush with gnt=1: pc_f<=flush_pc; go to DRAIN, because the old request was accepted.
- WAIT, no flush: on rvalid, instr_f<=rdata and go to HOLD, regardless of stall.
- WAIT, flush with rvalid=1: discard rdata; pc_f<=flush_pc; go to REQ.
- WAIT, flush with rvalid=0: pc_f<=flush_pc; go to DRAIN.
- HOLD, no flush: consume when stall=0, i.e. pc_f<=next_pc and go to REQ. With stall=1, hold pc_f, instr_f and valid_f.
- HOLD, flush: pc_f<=flush_pc; go to REQ. The held word is dropped.
- DRAIN: rvalid is discarded and the state goes to REQ. A flush in DRAIN updates pc_f only.
- Minimum latency: REQ, gnt (1 cycle), then rvalid the next cycle gives valid_f 2 cycles after imem_req first asserts. A consume returns to REQ the following cycle. Peak throughput is 1 instruction per 3 cycles.
- wait_cnt (8-bit): cleared on entry to WAIT or DRAIN; increments each cycle while in WAIT or DRAIN and saturates at TIMEOUT. When it reaches TIMEOUT, imem_timeout<=1 and stays 1 until reset. The state is not changed by a timeout.
- Arithmetic: pc_f is loaded only from RESET_PC, next_pc or flush_pc; there is no internal adder. Low bits pass through unmodified.
- instr_f keeps its last captured value outside HOLD.

Decomposition:
- Shared package fetch_pkg holds:
  - the state enum: REQ=2'd0, WAIT=2'd1, HOLD=2'd2, DRAIN=2'd3;
  - the RESET_PC default constant (32'h0000_3000), also used by the PC reset elsewhere.
- No sub-module. The timeout counter is inline.

Test Plan:
1. Reset, then gnt=1 on cycle 1 and rvalid on cycle 2 with rdata=32'h3402_0001 -> imem_addr=0x3000 with imem_req=1 on cycle 0; valid_f=1, instr_f=0x34020001, pc_f=0x3000 on cycle 3.
2. HOLD with stall=1 for 4 cycles, then stall=0 with next_pc=0x3004 -> valid_f stays 1 and pc_f stays 0x3000 for 4 cycles; next cycle state is REQ with imem_addr=0x3004.
3. Branch delay slot: HOLD at pc 0x3008 while next_pc=0x3020 (branch in D) -> after consume, imem_addr=0x3020.
4. flush with flush_pc=0x4180 in WAIT with no rvalid; rvalid(0xDEADBEEF) arrives 2 cycles later -> DRAIN, word dropped, valid_f never 1 for it; the next request has imem_addr=0x4180.
5. flush in REQ on the same cycle as gnt -> DRAIN, then REQ at flush_pc. flush and rvalid in the same cycle in WAIT -> straight to REQ; instr_f unchanged.
6. TIMEOUT=4 with gnt=1 and rvalid withheld -> imem_timeout rises after 4 WAIT cycles and stays 1 after a later rvalid. reset=0 clears it to 0 and returns imem_addr to 0x3000.
